uart_char_arbiter: RTL and testbench

- Shares the single uart_tx transmitter between two character sources: A, the USB-PD decoder stream, and B, the status/event message stream.
- Each source has its own FIFO. Arbitration is line-atomic, so lines from A and B never interleave on the serial output.
- The block sits between the character producers and uart_tx, driving send_trig/send_data and monitoring tx_bsy.

---
 rtl/uart_char_arbiter.sv | 257 +++++++++++++++++++++++++
 tb/tb_uart_char_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_char_arbiter.sv
// Line-atomic arbiter sharing one uart_tx between two buffered character sources.
// Optional macro ARB_SRC_TAG_EN: prefix every newly granted line with TAG_A / TAG_B.

module uart_char_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             wr_char,
  input  logic                   wr_valid,
  input  logic                   rd_pop,
  input  logic                   ovf_clr,
  output logic [7:0]             rd_char,
  output logic                   empty,
  output logic                   ovf,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          push;
  logic          pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign push    = wr_valid && !full;
  assign pop     = rd_pop && !empty;
  assign rd_char = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_char;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      // a drop at full outranks a simultaneous clear
      if (wr_valid && full) ovf <= 1'b1;
      else if (ovf_clr)     ovf <= 1'b0;
    end
  end

endmodule

module uart_char_arbiter #(
  parameter int         DEPTH        = 16,
  parameter logic [7:0] EOL_CHAR     = 8'h0A,
  parameter int         LOCK_TIMEOUT = 27000,
  parameter int         BSY_TIMEOUT  = 64,
  parameter logic [7:0] TAG_A        = 8'h41,
  parameter logic [7:0] TAG_B        = 8'h42
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             a_char,
  input  logic                   a_valid,
  input  logic [7:0]             b_char,
  input  logic                   b_valid,
  input  logic                   tx_bsy,
  input  logic                   ovf_clr,
  output logic                   send_trig,
  output logic [7:0]             send_data,
  output logic                   a_ovf,
  output logic                   b_ovf,
  output logic [$clog2(DEPTH):0] a_level,
  output logic [$clog2(DEPTH):0] b_level
);

  localparam int   LCW   = $clog2(LOCK_TIMEOUT + 1);
  localparam int   BCW   = $clog2(BSY_TIMEOUT + 1);
  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_t;

  state_t         state, state_nxt;
  logic           locked, locked_nxt;
  logic           owner, owner_nxt;
  logic           rr_last, rr_last_nxt;
  logic [LCW-1:0] lock_cnt, lock_cnt_nxt;
  logic [BCW-1:0] bsy_cnt, bsy_cnt_nxt;
  logic           trig_nxt;
  logic [7:0]     data_nxt;
  logic [7:0]     char_p0;
  logic           pop_a, pop_b;
  logic [7:0]     a_rd, b_rd;
  logic           a_empty, b_empty;
  logic           grant_src;
  logic           own_ne;
  logic           is_tag;
  logic [7:0]     tag_char;

  uart_char_fifo #(.DEPTH(DEPTH)) u_fifo_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_char  (a_char),
    .wr_valid (a_valid),
    .rd_pop   (pop_a),
    .ovf_clr  (ovf_clr),
    .rd_char  (a_rd),
    .empty    (a_empty),
    .ovf      (a_ovf),
    .level    (a_level)
  );

  uart_char_fifo #(.DEPTH(DEPTH)) u_fifo_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_char  (b_char),
    .wr_valid (b_valid),
    .rd_pop   (pop_b),
    .ovf_clr  (ovf_clr),
    .rd_char  (b_rd),
    .empty    (b_empty),
    .ovf      (b_ovf),
    .level    (b_level)
  );

  // contention goes to the source that did not finish the previous line
  assign grant_src = (!a_empty && !b_empty) ? ~rr_last : !b_empty;
  assign own_ne    = (owner == SRC_B) ? !b_empty : !a_empty;
  assign tag_char  = (owner == SRC_B) ? TAG_B : TAG_A;

`ifdef ARB_SRC_TAG_EN
  logic tag_p0, tag_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tag_p0 <= 1'b0;
    else        tag_p0 <= tag_nxt;
  end

  assign is_tag = tag_p0;
`else
  assign is_tag = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    locked_nxt   = locked;
    owner_nxt    = owner;
    rr_last_nxt  = rr_last;
    lock_cnt_nxt = '0;
    bsy_cnt_nxt  = '0;
    trig_nxt     = 1'b0;
    data_nxt     = send_data;
    pop_a        = 1'b0;
    pop_b        = 1'b0;
`ifdef ARB_SRC_TAG_EN
    tag_nxt      = tag_p0;
`endif
    unique case (state)
      IDLE: begin
        if (!locked) begin
          if ((!a_empty || !b_empty) && !tx_bsy) begin
            locked_nxt = 1'b1;
            owner_nxt  = grant_src;
            state_nxt  = SEND;
`ifdef ARB_SRC_TAG_EN
            tag_nxt    = 1'b1;
`else
            pop_a      = (grant_src == SRC_A);
            pop_b      = (grant_src == SRC_B);
`endif
          end
        end else if (own_ne) begin
          if (!tx_bsy) begin
            pop_a     = (owner == SRC_A);
            pop_b     = (owner == SRC_B);
            state_nxt = SEND;
          end
        end else if (lock_cnt == LCW'(LOCK_TIMEOUT - 1)) begin
          locked_nxt  = 1'b0;
          rr_last_nxt = owner;
        end else begin
          lock_cnt_nxt = lock_cnt + LCW'(1);
        end
      end
      SEND: begin
        if (!tx_bsy) begin
          trig_nxt  = 1'b1;
          data_nxt  = is_tag ? tag_char : char_p0;
          state_nxt = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (tx_bsy) begin
          state_nxt = WAIT_LO;
        end else if (bsy_cnt == BCW'(BSY_TIMEOUT - 1)) begin
          state_nxt = IDLE;
`ifdef ARB_SRC_TAG_EN
          tag_nxt   = 1'b0;
`endif
        end else begin
          bsy_cnt_nxt = bsy_cnt + BCW'(1);
        end
      end
      WAIT_LO: begin
        if (!tx_bsy) begin
          state_nxt = IDLE;
          if (!is_tag && (send_data == EOL_CHAR)) begin
            locked_nxt  = 1'b0;
            rr_last_nxt = owner;
          end
`ifdef ARB_SRC_TAG_EN
          tag_nxt   = 1'b0;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // stage p0: popped character held until its SEND slot
  always_ff @(posedge clk) begin
    if (pop_a || pop_b) char_p0 <= pop_b ? b_rd : a_rd;
  end

  // stage p1: registered trigger and data toward uart_tx
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      locked    <= 1'b0;
      owner     <= SRC_A;
      rr_last   <= SRC_B;
      lock_cnt  <= '0;
      bsy_cnt   <= '0;
      send_trig <= 1'b0;
      send_data <= 8'h00;
    end else begin
      state     <= state_nxt;
      locked    <= locked_nxt;
      owner     <= owner_nxt;
      rr_last   <= rr_last_nxt;
      lock_cnt  <= lock_cnt_nxt;
      bsy_cnt   <= bsy_cnt_nxt;
      send_trig <= trig_nxt;
      send_data <= data_nxt;
    end
  end

endmodule

// File: tb/tb_uart_char_arbiter.sv
// Scoreboard bench for uart_char_arbiter with a behavioural uart_tx busy model.
module tb_uart_char_arbiter;

  localparam int DEPTH = 16;
  localparam int LT    = 300;
  localparam int BT    = 20;
`ifdef ARB_SRC_TAG_EN
  localparam int TAGN  = 1;
`else
  localparam int TAGN  = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a_char, b_char;
  logic       a_valid, b_valid;
  logic       tx_bsy;
  logic       ovf_clr;
  logic       send_trig;
  logic [7:0] send_data;
  logic       a_ovf, b_ovf;
  logic [$clog2(DEPTH):0] a_level, b_level;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int bsy_mode = 0;
  int bsy_cnt  = 0;
  int last_push_cyc = 0;
  int p0, base, gap, k;
  logic [7:0] exp_q [$];
  int trig_cyc_q [$];
  logic [7:0] mon_exp;

  always #5 clk = ~clk;

  uart_char_arbiter #(
    .DEPTH(DEPTH), .EOL_CHAR(8'h0A), .LOCK_TIMEOUT(LT), .BSY_TIMEOUT(BT),
    .TAG_A(8'h41), .TAG_B(8'h42)
  ) dut (
    .clk(clk), .rst_n(rst_n), .a_char(a_char), .a_valid(a_valid),
    .b_char(b_char), .b_valid(b_valid), .tx_bsy(tx_bsy), .ovf_clr(ovf_clr),
    .send_trig(send_trig), .send_data(send_data), .a_ovf(a_ovf), .b_ovf(b_ovf),
    .a_level(a_level), .b_level(b_level)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // uart_tx model: 0 = busy 10 cycles per trig, 1 = stuck high, 2 = tied low
  always @(negedge clk) begin
    if (bsy_mode == 1) begin
      tx_bsy = 1'b1;
    end else if (bsy_mode == 2) begin
      tx_bsy = 1'b0;
    end else begin
      if (send_trig) bsy_cnt = 10;
      else if (bsy_cnt > 0) bsy_cnt = bsy_cnt - 1;
      tx_bsy = (bsy_cnt != 0);
    end
  end

  // monitor: every trig consumes one expected character
  always begin
    @(posedge clk);
    #1;
    if (rst_n && send_trig) begin
      trig_cyc_q.push_back(cyc);
      check("trig_while_busy", 32'(tx_bsy), 32'd0);
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_trig: got data 0x%0h, expected no transmission", send_data);
      end else begin
        mon_exp = exp_q.pop_front();
        check("send_data", 32'(send_data), 32'(mon_exp));
      end
    end
  end

  task automatic do_reset();
    rst_n   = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    a_char  = 8'h00;
    b_char  = 8'h00;
    ovf_clr = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.delete();
    trig_cyc_q.delete();
    bsy_cnt = 0;
    rst_n   = 1'b1;
  endtask

  task automatic push(input logic av, input logic [7:0] ac, input logic bv, input logic [7:0] bc);
    @(negedge clk);
    a_valid = av;
    a_char  = ac;
    b_valid = bv;
    b_char  = bc;
    @(posedge clk);
    #1;
    last_push_cyc = cyc;
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic exp_tag(input logic src);
    if (TAGN != 0) exp_q.push_back(src ? 8'h42 : 8'h41);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || tx_bsy) && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (n >= budget) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: %0d characters still pending, expected 0", name, exp_q.size());
    end
    repeat (15) @(posedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    tx_bsy = 1'b0;
    bsy_mode = 0;
    do_reset();
    @(posedge clk); #1;
    check("rst_trig",    32'(send_trig), 32'd0);
    check("rst_data",    32'(send_data), 32'd0);
    check("rst_a_ovf",   32'(a_ovf),     32'd0);
    check("rst_b_ovf",   32'(b_ovf),     32'd0);
    check("rst_a_level", 32'(a_level),   32'd0);
    check("rst_b_level", 32'(b_level),   32'd0);

    // single line from A, first trig two edges after the push edge
    exp_tag(1'b0);
    exp_q.push_back(8'h48); exp_q.push_back(8'h49); exp_q.push_back(8'h0A);
    push(1'b1, 8'h48, 1'b0, 8'h00);
    p0 = last_push_cyc;
    push(1'b1, 8'h49, 1'b0, 8'h00);
    push(1'b1, 8'h0A, 1'b0, 8'h00);
    wait_drain("hi_line", 400);
    check("hi_trig_count", 32'(trig_cyc_q.size()), 32'(3 + TAGN));
    if (trig_cyc_q.size() > 0) check("hi_latency", 32'(trig_cyc_q[0] - p0), 32'd2);

    // simultaneous start: A wins, B waits for the A lock timeout
    do_reset();
    exp_tag(1'b0); exp_q.push_back(8'h41); exp_q.push_back(8'h42);
    exp_tag(1'b1); exp_q.push_back(8'h58); exp_q.push_back(8'h59); exp_q.push_back(8'h0A);
    push(1'b1, 8'h41, 1'b1, 8'h58);
    push(1'b1, 8'h42, 1'b1, 8'h59);
    push(1'b0, 8'h00, 1'b1, 8'h0A);
    wait_drain("contend", LT + 600);
    check("contend_trig_count", 32'(trig_cyc_q.size()), 32'(5 + 2 * TAGN));
    if (trig_cyc_q.size() > 3 + TAGN) begin
      gap = trig_cyc_q[2 + TAGN] - trig_cyc_q[1 + TAGN];
      check("contend_lock_gap", 32'(gap >= LT && gap <= LT + 20), 32'd1);
    end
    check("contend_b_level", 32'(b_level), 32'd0);

    // round robin after each EOL
    do_reset();
    exp_tag(1'b0); exp_q.push_back(8'h31); exp_q.push_back(8'h0A);
    exp_tag(1'b1); exp_q.push_back(8'h32); exp_q.push_back(8'h0A);
    exp_tag(1'b0); exp_q.push_back(8'h33); exp_q.push_back(8'h0A);
    exp_tag(1'b1); exp_q.push_back(8'h34); exp_q.push_back(8'h0A);
    push(1'b1, 8'h31, 1'b0, 8'h00);
    push(1'b1, 8'h0A, 1'b0, 8'h00);
    push(1'b0, 8'h00, 1'b1, 8'h32);
    push(1'b0, 8'h00, 1'b1, 8'h0A);
    push(1'b1, 8'h33, 1'b0, 8'h00);
    push(1'b1, 8'h0A, 1'b0, 8'h00);
    push(1'b0, 8'h00, 1'b1, 8'h34);
    push(1'b0, 8'h00, 1'b1, 8'h0A);
    wait_drain("rr", 1000);
    check("rr_trig_count", 32'(trig_cyc_q.size()), 32'(8 + 4 * TAGN));

    // overflow with tx_bsy stuck high, then drain
    bsy_mode = 1;
    do_reset();
    repeat (2) @(negedge clk);
    for (int i = 0; i <= DEPTH; i++) push(1'b1, 8'(8'h60 + i), 1'b0, 8'h00);
    check("ovf_a_level", 32'(a_level), 32'(DEPTH));
    check("ovf_a_flag",  32'(a_ovf),   32'd1);
    check("ovf_b_flag",  32'(b_ovf),   32'd0);
    @(negedge clk);
    a_valid = 1'b1; a_char = 8'h7F; ovf_clr = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0; ovf_clr = 1'b0;
    check("ovf_drop_beats_clr", 32'(a_ovf), 32'd1);
    @(negedge clk);
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    check("ovf_cleared", 32'(a_ovf), 32'd0);
    check("ovf_no_trig_while_busy", 32'(trig_cyc_q.size()), 32'd0);
    exp_tag(1'b0);
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(8'(8'h60 + i));
    bsy_mode = 0;
    wait_drain("ovf_drain", 800);
    check("ovf_drain_count", 32'(trig_cyc_q.size()), 32'(DEPTH + TAGN));
    check("ovf_drain_level", 32'(a_level), 32'd0);

    // tx_bsy tied low: BSY_TIMEOUT wait between trigs
    bsy_mode = 2;
    do_reset();
    exp_tag(1'b0); exp_q.push_back(8'h70); exp_q.push_back(8'h71);
    push(1'b1, 8'h70, 1'b0, 8'h00);
    push(1'b1, 8'h71, 1'b0, 8'h00);
    wait_drain("bsy_low", 400);
    k = trig_cyc_q.size();
    check("bsy_low_trig_count", 32'(k), 32'(2 + TAGN));
    if (k >= 2) check("bsy_low_gap", 32'(trig_cyc_q[k-1] - trig_cyc_q[k-2]), 32'(BT + 2));

    // reset in the middle of a B line
    bsy_mode = 0;
    do_reset();
    exp_tag(1'b1);
    exp_q.push_back(8'h4F); exp_q.push_back(8'h4B); exp_q.push_back(8'h0A);
    push(1'b0, 8'h00, 1'b1, 8'h4F);
    push(1'b0, 8'h00, 1'b1, 8'h4B);
    push(1'b0, 8'h00, 1'b1, 8'h0A);
    k = 0;
    while (trig_cyc_q.size() < 1 + TAGN && k < 100) begin
      @(posedge clk);
      k++;
    end
    check("midline_started", 32'(trig_cyc_q.size() >= 1 + TAGN), 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    check("midrst_trig",    32'(send_trig), 32'd0);
    check("midrst_data",    32'(send_data), 32'd0);
    check("midrst_b_level", 32'(b_level),   32'd0);
    check("midrst_b_ovf",   32'(b_ovf),     32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base = trig_cyc_q.size();
    repeat (60) @(posedge clk);
    #1;
    check("midrst_no_more_trig", 32'(trig_cyc_q.size()), 32'(base));
    check("midrst_a_level",      32'(a_level),           32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
